// File: rtl/cv32e40p_ft_pipe_stage.sv
// Fault-tolerant two-entry pipeline stage (main + skid) with optional
// triple modular redundancy, per-cycle scrubbing and a saturating error counter.
module cv32e40p_ft_pipe_stage #(
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    TMR           = 1,
    parameter int                    ERR_CNT_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL     = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [DATA_WIDTH-1:0]    in_data_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [DATA_WIDTH-1:0]    out_data_o,
    output logic                     err_o,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt_o,
    input  logic                     err_cnt_clr_i
);

    localparam int NCOPY = (TMR != 0) ? 3 : 1;

    logic [NCOPY-1:0]                 main_valid_q, main_valid_d;
    logic [NCOPY-1:0]                 skid_valid_q, skid_valid_d;
    logic [NCOPY-1:0][DATA_WIDTH-1:0] main_data_q, main_data_d;
    logic [NCOPY-1:0][DATA_WIDTH-1:0] skid_data_q, skid_data_d;
    logic [ERR_CNT_WIDTH-1:0]         err_cnt_q, err_cnt_d;

    // Voted views of every register; all decisions below use only these.
    logic                  main_valid_v, skid_valid_v;
    logic [DATA_WIDTH-1:0] main_data_v, skid_data_v;
    logic                  err_w;

    if (TMR != 0) begin : g_tmr
        assign main_valid_v = (main_valid_q[0] & main_valid_q[1]) |
                              (main_valid_q[0] & main_valid_q[2]) |
                              (main_valid_q[1] & main_valid_q[2]);
        assign skid_valid_v = (skid_valid_q[0] & skid_valid_q[1]) |
                              (skid_valid_q[0] & skid_valid_q[2]) |
                              (skid_valid_q[1] & skid_valid_q[2]);
        assign main_data_v  = (main_data_q[0] & main_data_q[1]) |
                              (main_data_q[0] & main_data_q[2]) |
                              (main_data_q[1] & main_data_q[2]);
        assign skid_data_v  = (skid_data_q[0] & skid_data_q[1]) |
                              (skid_data_q[0] & skid_data_q[2]) |
                              (skid_data_q[1] & skid_data_q[2]);
        assign err_w = |{main_valid_q ^ {NCOPY{main_valid_v}},
                         skid_valid_q ^ {NCOPY{skid_valid_v}},
                         main_data_q  ^ {NCOPY{main_data_v}},
                         skid_data_q  ^ {NCOPY{skid_data_v}}};
    end else begin : g_single
        assign main_valid_v = main_valid_q[0];
        assign skid_valid_v = skid_valid_q[0];
        assign main_data_v  = main_data_q[0];
        assign skid_data_v  = skid_data_q[0];
        assign err_w        = 1'b0;
    end

    logic accept, drain;
    logic n_main_valid, n_skid_valid;
    logic [DATA_WIDTH-1:0] n_main_data, n_skid_data;

    assign in_ready_o  = ~skid_valid_v;
    assign out_valid_o = main_valid_v;
    assign out_data_o  = main_data_v;
    assign err_o       = err_w;
    assign err_cnt_o   = err_cnt_q;
    assign accept      = in_valid_i & in_ready_o;
    assign drain       = out_valid_o & out_ready_i;

    // Next entry state from voted values; every copy is rewritten (scrubbed) each cycle.
    always_comb begin
        n_main_valid = main_valid_v;
        n_main_data  = main_data_v;
        n_skid_valid = skid_valid_v;
        n_skid_data  = skid_data_v;
        if (flush_i) begin
            n_main_valid = 1'b0;
            n_skid_valid = 1'b0;
        end else if (drain) begin
            if (skid_valid_v) begin
                n_main_valid = 1'b1;
                n_main_data  = skid_data_v;
                n_skid_valid = 1'b0;
            end else if (accept) begin
                n_main_valid = 1'b1;
                n_main_data  = in_data_i;
            end else begin
                n_main_valid = 1'b0;
            end
        end else if (accept) begin
            if (!main_valid_v) begin
                n_main_valid = 1'b1;
                n_main_data  = in_data_i;
            end else begin
                n_skid_valid = 1'b1;
                n_skid_data  = in_data_i;
            end
        end
        main_valid_d = {NCOPY{n_main_valid}};
        skid_valid_d = {NCOPY{n_skid_valid}};
        main_data_d  = {NCOPY{n_main_data}};
        skid_data_d  = {NCOPY{n_skid_data}};
    end

    // Saturating count of cycles with a copy mismatch; clear wins over increment.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_cnt_clr_i) begin
            err_cnt_d = '0;
        end else if (err_w && (err_cnt_q != {ERR_CNT_WIDTH{1'b1}})) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= '0;
            skid_valid_q <= '0;
            main_data_q  <= {NCOPY{RESET_VAL}};
            skid_data_q  <= {NCOPY{RESET_VAL}};
            err_cnt_q    <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_cv32e40p_ft_pipe_stage.sv
// Directed self-checking bench for cv32e40p_ft_pipe_stage (TMR=1, 2-bit counter).
module tb_cv32e40p_ft_pipe_stage;

    localparam int DW = 32;
    localparam int CW = 2;

    logic          clk;
    logic          rst_n;
    logic          flush_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [DW-1:0] in_data_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [DW-1:0] out_data_o;
    logic          err_o;
    logic [CW-1:0] err_cnt_o;
    logic          err_cnt_clr_i;

    int checks = 0;
    int errors = 0;

    cv32e40p_ft_pipe_stage #(
        .DATA_WIDTH   (DW),
        .TMR          (1),
        .ERR_CNT_WIDTH(CW),
        .RESET_VAL    (32'hDEAD_BEEF)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (flush_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_data_i    (in_data_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_data_o   (out_data_o),
        .err_o        (err_o),
        .err_cnt_o    (err_cnt_o),
        .err_cnt_clr_i(err_cnt_clr_i)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: count it, and on mismatch count and report it.
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock: inputs are driven and outputs sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    // Corrupt bit 0 of main data copy 1 between clock edges (models a single upset).
    task automatic inject_upset();
        #1 force dut.main_data_q = 96'h0000_0000_0000_0001_0000_0000;
        #1 release dut.main_data_q;
        #1;
    endtask

    // Directed sequence.
    initial begin
        rst_n = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0;
        out_ready_i = 1'b0; err_cnt_clr_i = 1'b0;
        step();
        check("rst_out_valid", out_valid_o, 0);
        check("rst_in_ready", in_ready_o, 1);
        check("rst_err", err_o, 0);
        check("rst_err_cnt", err_cnt_o, 0);
        check("rst_out_data", out_data_o, 32'hDEAD_BEEF);
        rst_n = 1'b1;

        // Single transfer, latency 1.
        in_valid_i = 1'b1; in_data_i = 32'hA5A5_A5A5; out_ready_i = 1'b1;
        step();
        check("a5_valid", out_valid_o, 1);
        check("a5_data", out_data_o, 32'hA5A5_A5A5);
        check("a5_ready", in_ready_o, 1);
        in_valid_i = 1'b0;
        step();
        check("drain_valid", out_valid_o, 0);
        check("drain_data_kept", out_data_o, 32'hA5A5_A5A5);

        // Back-pressure: fill main and skid, then release.
        out_ready_i = 1'b0; in_valid_i = 1'b1; in_data_i = 32'h1;
        step();
        check("bp1_data", out_data_o, 32'h1);
        check("bp1_ready", in_ready_o, 1);
        in_data_i = 32'h2;
        step();
        check("bp2_data", out_data_o, 32'h1);
        check("bp2_ready", in_ready_o, 0);
        in_data_i = 32'h3;
        step();
        check("bp3_data", out_data_o, 32'h1);
        check("bp3_ready", in_ready_o, 0);
        out_ready_i = 1'b1;
        step();
        check("rel_data2", out_data_o, 32'h2);
        check("rel_ready", in_ready_o, 1);
        step();
        check("rel_data3", out_data_o, 32'h3);
        check("rel_valid3", out_valid_o, 1);
        in_valid_i = 1'b0;
        step();
        check("rel_empty", out_valid_o, 0);

        // Sustained streaming: one transfer per cycle.
        in_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data_i = 32'h10 + i;
            step();
            check("stream_valid", out_valid_o, 1);
            check("stream_data", out_data_o, 32'h10 + i);
            check("stream_ready", in_ready_o, 1);
        end
        in_valid_i = 1'b0;
        step();

        // Flush with both entries full and a simultaneous accept.
        out_ready_i = 1'b0; in_valid_i = 1'b1; in_data_i = 32'h55;
        step();
        in_data_i = 32'h66;
        step();
        check("full_ready", in_ready_o, 0);
        flush_i = 1'b1; in_data_i = 32'h77; out_ready_i = 1'b1;
        step();
        check("flush_valid", out_valid_o, 0);
        check("flush_ready", in_ready_o, 1);
        check("flush_data_kept", out_data_o, 32'h55);
        flush_i = 1'b0; in_valid_i = 1'b0;
        step();
        check("flush_no_leak", out_valid_o, 0);
        in_valid_i = 1'b1; in_data_i = 32'h88;
        step();
        check("post_flush_data", out_data_o, 32'h88);
        in_valid_i = 1'b0;
        step();

        // Single upset in main data while holding 0x0.
        out_ready_i = 1'b0; in_valid_i = 1'b1; in_data_i = 32'h0;
        step();
        in_valid_i = 1'b0;
        check("hold0_valid", out_valid_o, 1);
        inject_upset();
        check("upset_err", err_o, 1);
        check("upset_data", out_data_o, 32'h0);
        step();
        check("scrub_err", err_o, 0);
        check("scrub_cnt", err_cnt_o, 1);
        check("scrub_data", out_data_o, 32'h0);
        check("scrub_copies", dut.main_data_q, 96'h0);

        // Saturation of the 2-bit counter over five consecutive mismatch cycles.
        for (int i = 0; i < 5; i++) begin
            inject_upset();
            step();
            check("sat_cnt", err_cnt_o, (i + 2 > 3) ? 3 : i + 2);
        end
        inject_upset();
        err_cnt_clr_i = 1'b1;
        step();
        err_cnt_clr_i = 1'b0;
        check("clr_cnt", err_cnt_o, 0);
        check("clr_hold_data", out_data_o, 32'h0);

        // Asynchronous reset mid-transfer with both entries full.
        in_valid_i = 1'b1; in_data_i = 32'hAB;
        step();
        check("prereset_full", in_ready_o, 0);
        inject_upset();
        step();
        check("prereset_cnt", err_cnt_o, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid_o, 0);
        check("async_rst_ready", in_ready_o, 1);
        check("async_rst_cnt", err_cnt_o, 0);
        check("async_rst_data", out_data_o, 32'hDEAD_BEEF);
        in_valid_i = 1'b0;
        step();
        rst_n = 1'b1;
        in_valid_i = 1'b1; in_data_i = 32'hC3; out_ready_i = 1'b1;
        step();
        check("post_rst_data", out_data_o, 32'hC3);
        check("post_rst_valid", out_valid_o, 1);
        in_valid_i = 1'b0;
        step();
        check("post_rst_empty", out_valid_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
